// File: rtl/rvv_vrf_mp_pkg.sv
// rvv_vrf_mp_pkg
// Shared definitions for the multi-ported vector register file.
// Contents:
//   - default parameter values (VLEN, NREG, NUM_RD, NUM_WR) and derived widths
//   - BEW: byte-enable width for the default VLEN
//   - vrf_state_e: INIT (zero-fill sweep) / RUN (normal operation)
//   - WB_VRF_t: one write-back request (register index, byte enable, data)
//   - be_overlap(): true when two byte-enable masks share any byte
package rvv_vrf_mp_pkg;

    localparam int VLEN_DEF   = 128;
    localparam int NREG_DEF   = 32;
    localparam int NUM_RD_DEF = 4;
    localparam int NUM_WR_DEF = 4;
    localparam int IDXW_DEF   = $clog2(NREG_DEF);
    localparam int BEW        = VLEN_DEF / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } vrf_state_e;

    // The request record is sized by the package defaults; the register file
    // uses the low IDXW/BEW/VLEN bits of each field.
    typedef struct packed {
        logic [IDXW_DEF-1:0] idx;
        logic [BEW-1:0]      be;
        logic [VLEN_DEF-1:0] data;
    } WB_VRF_t;

    function automatic logic be_overlap(input logic [BEW-1:0] a, input logic [BEW-1:0] b);
        return |(a & b);
    endfunction

endpackage

// File: rtl/rvv_vrf_mp_if.sv
// rvv_vrf_mp_if
// Bundles the read ports, the write-back request ports and the status of the
// vector register file.
//   rd_index  : per read port register index        (master -> slave)
//   rd_data   : per read port register contents     (slave -> master)
//   v0_mask   : contents of register 0              (slave -> master)
//   wr_valid  : per write port request valid        (master -> slave)
//   wr_req    : per write port WB_VRF_t request     (master -> slave)
//   wr_ready  : per write port accept this cycle    (slave -> master)
//   init_done : zero-fill sweep complete            (slave -> master)
// Modports: master = the vector pipeline, slave = the register file.
interface rvv_vrf_mp_if
    import rvv_vrf_mp_pkg::*;
#(
    parameter int VLEN   = VLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
);
    localparam int IDXW = $clog2(NREG);

    logic [NUM_RD-1:0][IDXW-1:0] rd_index;
    logic [NUM_RD-1:0][VLEN-1:0] rd_data;
    logic [VLEN-1:0]             v0_mask;
    logic [NUM_WR-1:0]           wr_valid;
    WB_VRF_t [NUM_WR-1:0]        wr_req;
    logic [NUM_WR-1:0]           wr_ready;
    logic                        init_done;

    modport master (
        output rd_index, wr_valid, wr_req,
        input  rd_data, v0_mask, wr_ready, init_done
    );

    modport slave (
        input  rd_index, wr_valid, wr_req,
        output rd_data, v0_mask, wr_ready, init_done
    );

endinterface

// File: rtl/rvv_vrf_wr_arb.sv
// rvv_vrf_wr_arb
// Write-port conflict resolution for the vector register file.
//   run      : in  1               register file is in RUN and not in reset
//   wr_valid : in  NUM_WR          request valid per port
//   wr_index : in  NUM_WR x IDXW   target register per port
//   wr_be    : in  NUM_WR x BEW    byte enable per port
//   wr_ready : out NUM_WR          port may commit at the next edge
// Fixed priority by port number: a port is held off only when a lower-numbered
// valid port writes the same register and at least one of the same bytes, so
// disjoint byte lanes of one register can all be accepted together.
module rvv_vrf_wr_arb #(
    parameter int NUM_WR = 4,
    parameter int IDXW   = 5,
    parameter int BEW    = 16
) (
    input  logic                        run,
    input  logic [NUM_WR-1:0]           wr_valid,
    input  logic [NUM_WR-1:0][IDXW-1:0] wr_index,
    input  logic [NUM_WR-1:0][BEW-1:0]  wr_be,
    output logic [NUM_WR-1:0]           wr_ready
);

    logic [NUM_WR-1:0] blocked;

    // Compare every port against all lower-numbered ports. A zero byte enable
    // never overlaps anything, so such requests always go through.
    always_comb begin
        blocked = '0;
        for (int w = 1; w < NUM_WR; w++) begin
            for (int j = 0; j < w; j++) begin
                if (wr_valid[j] && (wr_index[j] == wr_index[w]) && |(wr_be[j] & wr_be[w])) begin
                    blocked[w] = 1'b1;
                end
            end
        end
        wr_ready = run ? ~blocked : '0;
    end

endmodule

// File: rtl/rvv_vrf_mp.sv
// rvv_vrf_mp
// Multi-ported vector register file built from flops.
//   clk : in  1  clock
//   rst : in  1  synchronous active-high reset
//   vrf : rvv_vrf_mp_if.slave
//         rd_index/rd_data  combinational read ports
//         v0_mask           register 0 contents
//         wr_valid/wr_req/wr_ready  byte-masked write ports (valid/ready)
//         init_done         high once the zero-fill sweep has finished
// After reset the file sweeps one register per cycle to zero (INIT), then
// serves reads and writes (RUN). Writes become visible the cycle after they
// commit; there is no write-to-read bypass.
module rvv_vrf_mp
    import rvv_vrf_mp_pkg::*;
#(
    parameter int VLEN   = VLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic         clk,
    input  logic         rst,
    rvv_vrf_mp_if.slave  vrf
);

    localparam int IDXW = $clog2(NREG);
    localparam int BEW  = VLEN / 8;

    vrf_state_e state, state_nxt;
    logic [IDXW-1:0] cnt, cnt_nxt;
    logic            run;

    logic [VLEN-1:0] regs [NREG];

    logic [NUM_WR-1:0][IDXW-1:0] wr_index;
    logic [NUM_WR-1:0][BEW-1:0]  wr_be;
    logic [NUM_WR-1:0][VLEN-1:0] wr_data;

    // Unpack the request records into plain per-port fields of this
    // instance's widths.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_index[w] = vrf.wr_req[w].idx[IDXW-1:0];
            wr_be[w]    = vrf.wr_req[w].be[BEW-1:0];
            wr_data[w]  = vrf.wr_req[w].data[VLEN-1:0];
        end
    end

    // State and sweep counter. Reset restarts the sweep from register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The sweep ends on the cycle that zeroes the last register; the counter
    // then parks there rather than wrapping.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == ST_INIT) begin
            if (cnt == IDXW'(NREG - 1)) begin
                state_nxt = ST_RUN;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Reset also masks readiness and init_done in the cycle it is asserted,
    // so writes presented alongside reset are dropped.
    assign run           = (state == ST_RUN) && !rst;
    assign vrf.init_done = run;

    rvv_vrf_wr_arb #(
        .NUM_WR (NUM_WR),
        .IDXW   (IDXW),
        .BEW    (BEW)
    ) u_wr_arb (
        .run      (run),
        .wr_valid (vrf.wr_valid),
        .wr_index (wr_index),
        .wr_be    (wr_be),
        .wr_ready (vrf.wr_ready)
    );

    // Storage update: zero-fill during INIT, byte-masked commits during RUN.
    // Accepted writes never share a byte, so port order does not matter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                regs[cnt] <= '0;
            end else begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (vrf.wr_valid[w] && vrf.wr_ready[w]) begin
                        for (int b = 0; b < BEW; b++) begin
                            if (wr_be[w][b]) begin
                                regs[wr_index[w]][b*8 +: 8] <= wr_data[w][b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Combinational reads; the array is not initialised until the sweep has
    // finished, so everything reads as zero during INIT.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            vrf.rd_data[p] = (state == ST_RUN) ? regs[vrf.rd_index[p]] : '0;
        end
        vrf.v0_mask = (state == ST_RUN) ? regs[0] : '0;
    end

endmodule

// File: tb/tb_rvv_vrf_mp.sv
// tb_rvv_vrf_mp
// Self-checking bench for rvv_vrf_mp at default parameters: reset/sweep
// timing, a table of directed write vectors, randomized traffic checked
// against a behavioural register-file model, and reset during RUN.
module tb_rvv_vrf_mp;
    import rvv_vrf_mp_pkg::*;

    localparam int VLEN = 128;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rvv_vrf_mp_if #(.VLEN(VLEN), .NREG(NREG), .NUM_RD(NRD), .NUM_WR(NWR)) bus();

    rvv_vrf_mp #(.VLEN(VLEN), .NREG(NREG), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .vrf (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [VLEN-1:0] model_mem [NREG];

    logic [NWR-1:0]            cur_valid;
    logic [NWR-1:0][4:0]       cur_idx;
    logic [NWR-1:0][15:0]      cur_be;
    logic [NWR-1:0][VLEN-1:0]  cur_data;

    typedef struct {
        logic [NWR-1:0]           valid;
        logic [NWR-1:0][4:0]      idx;
        logic [NWR-1:0][15:0]     be;
        logic [NWR-1:0][VLEN-1:0] data;
        logic [NWR-1:0]           exp_ready;
        logic [4:0]               chk_reg;
        logic [VLEN-1:0]          exp_before;
        logic [VLEN-1:0]          exp_after;
    } vec_t;

    vec_t table_v [8];

    task automatic check_output(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [NWR-1:0] valid, input logic [NWR-1:0][4:0] idx,
                                  input logic [NWR-1:0][15:0] be, input logic [NWR-1:0][VLEN-1:0] data);
        cur_valid = valid;
        cur_idx   = idx;
        cur_be    = be;
        cur_data  = data;
        for (int w = 0; w < NWR; w++) begin
            bus.wr_valid[w]    = valid[w];
            bus.wr_req[w].idx  = idx[w];
            bus.wr_req[w].be   = be[w];
            bus.wr_req[w].data = data[w];
        end
    endtask

    task automatic clear_writes();
        apply_stimulus('0, '0, '0, '0);
    endtask

    // Acceptance rule: a request waits while any lower port with a valid
    // request hits the same register in a shared byte.
    function automatic logic [NWR-1:0] model_ready();
        logic [NWR-1:0] r;
        for (int w = 0; w < NWR; w++) begin
            r[w] = 1'b1;
            for (int j = 0; j < w; j++) begin
                if (cur_valid[j] && cur_idx[j] == cur_idx[w] && (cur_be[j] & cur_be[w]) != 16'h0)
                    r[w] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic model_commit(input logic [NWR-1:0] acc);
        for (int w = 0; w < NWR; w++) begin
            if (cur_valid[w] && acc[w]) begin
                for (int b = 0; b < VLEN/8; b++) begin
                    if (cur_be[w][b]) model_mem[cur_idx[w]][b*8 +: 8] = cur_data[w][b*8 +: 8];
                end
            end
        end
    endtask

    task automatic model_zero();
        for (int r = 0; r < NREG; r++) model_mem[r] = '0;
    endtask

    // Releases reset at a falling edge with writes held valid, then checks the
    // sweep length, INIT behaviour and that every register reads zero.
    task automatic sweep_and_check(input string tag);
        logic [NWR-1:0][4:0]      idx;
        logic [NWR-1:0][15:0]     be;
        logic [NWR-1:0][VLEN-1:0] data;
        for (int w = 0; w < NWR; w++) begin
            idx[w]  = 5'(w + 4);
            be[w]   = 16'hFFFF;
            data[w] = {VLEN{1'b1}};
        end
        apply_stimulus({NWR{1'b1}}, idx, be, data);
        rst = 1'b0;
        for (int i = 1; i <= NREG; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                check_output({tag, "_init_ready"}, VLEN'(bus.wr_ready), '0);
                check_output({tag, "_init_rd"}, bus.rd_data[0], '0);
                check_output({tag, "_init_v0"}, bus.v0_mask, '0);
            end
            if (i == NREG - 1) check_output({tag, "_done_early"}, VLEN'(bus.init_done), '0);
            if (i == NREG)     check_output({tag, "_done_on_time"}, VLEN'(bus.init_done), VLEN'(1));
        end
        @(negedge clk);
        clear_writes();
        model_zero();
        for (int g = 0; g < NREG / NRD; g++) begin
            for (int p = 0; p < NRD; p++) bus.rd_index[p] = 5'(g * NRD + p);
            #1;
            for (int p = 0; p < NRD; p++)
                check_output($sformatf("%s_zero_r%0d", tag, g * NRD + p), bus.rd_data[p], '0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [NWR-1:0]           rnd_valid;
        logic [NWR-1:0][4:0]      rnd_idx;
        logic [NWR-1:0][15:0]     rnd_be;
        logic [NWR-1:0][VLEN-1:0] rnd_data;
        logic [NWR-1:0]           held;
        logic [NWR-1:0]           exp_r;

        // Directed vectors applied one cycle each from a zeroed file.
        for (int i = 0; i < 8; i++) begin
            table_v[i].valid      = '0;
            table_v[i].idx        = '0;
            table_v[i].be         = '0;
            table_v[i].data       = '0;
            table_v[i].exp_ready  = '1;
            table_v[i].chk_reg    = '0;
            table_v[i].exp_before = '0;
            table_v[i].exp_after  = '0;
        end
        table_v[0].valid = 4'b0001; table_v[0].idx[0] = 5; table_v[0].be[0] = 16'hFFFF;
        table_v[0].data[0] = {16{8'hA5}};
        table_v[0].chk_reg = 5; table_v[0].exp_after = {16{8'hA5}};

        table_v[1].valid = 4'b0101;
        table_v[1].idx[0] = 3; table_v[1].be[0] = 16'h00FF; table_v[1].data[0] = {16{8'h11}};
        table_v[1].idx[2] = 3; table_v[1].be[2] = 16'hFF00; table_v[1].data[2] = {16{8'h22}};
        table_v[1].chk_reg = 3; table_v[1].exp_after = {{8{8'h22}}, {8{8'h11}}};

        table_v[2].valid = 4'b1010;
        table_v[2].idx[1] = 7; table_v[2].be[1] = 16'hFFFF; table_v[2].data[1] = 128'h1;
        table_v[2].idx[3] = 7; table_v[2].be[3] = 16'hFFFF; table_v[2].data[3] = 128'h2;
        table_v[2].exp_ready = 4'b0111; table_v[2].chk_reg = 7; table_v[2].exp_after = 128'h1;

        table_v[3].valid = 4'b1000;
        table_v[3].idx[3] = 7; table_v[3].be[3] = 16'hFFFF; table_v[3].data[3] = 128'h2;
        table_v[3].chk_reg = 7; table_v[3].exp_before = 128'h1; table_v[3].exp_after = 128'h2;

        table_v[4].valid = 4'b0001; table_v[4].idx[0] = 0; table_v[4].be[0] = 16'h000F;
        table_v[4].data[0] = 128'hDEAD_BEEF;
        table_v[4].chk_reg = 0; table_v[4].exp_after = 128'hDEAD_BEEF;

        table_v[5].valid = 4'b0001; table_v[5].idx[0] = 5; table_v[5].be[0] = 16'h0000;
        table_v[5].data[0] = {VLEN{1'b1}};
        table_v[5].chk_reg = 5; table_v[5].exp_before = {16{8'hA5}}; table_v[5].exp_after = {16{8'hA5}};

        table_v[6].valid = 4'b0111;
        table_v[6].idx[0] = 9; table_v[6].be[0] = 16'h00F0; table_v[6].data[0] = {16{8'h33}};
        table_v[6].idx[1] = 9; table_v[6].be[1] = 16'h0F00; table_v[6].data[1] = {16{8'h44}};
        table_v[6].idx[2] = 9; table_v[6].be[2] = 16'h0FF0; table_v[6].data[2] = {16{8'h55}};
        table_v[6].exp_ready = 4'b1011; table_v[6].chk_reg = 9;
        table_v[6].exp_after = 128'h00000000_44444444_33333333_00000000;

        table_v[7].valid = 4'b0100;
        table_v[7].idx[2] = 9; table_v[7].be[2] = 16'h0FF0; table_v[7].data[2] = {16{8'h55}};
        table_v[7].chk_reg = 9;
        table_v[7].exp_before = 128'h00000000_44444444_33333333_00000000;
        table_v[7].exp_after  = 128'h00000000_55555555_55555555_00000000;

        // Reset phase: writes offered during reset must not be accepted.
        rst = 1'b1;
        for (int p = 0; p < NRD; p++) bus.rd_index[p] = '0;
        clear_writes();
        repeat (3) @(negedge clk);
        apply_stimulus(4'b1111, '0, {NWR{16'hFFFF}}, '0);
        #1;
        check_output("rst_ready", VLEN'(bus.wr_ready), '0);
        check_output("rst_init_done", VLEN'(bus.init_done), '0);
        @(negedge clk);

        sweep_and_check("sweep1");

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(table_v[i].valid, table_v[i].idx, table_v[i].be, table_v[i].data);
            bus.rd_index[0] = table_v[i].chk_reg;
            #1;
            check_output($sformatf("row%0d_ready", i), VLEN'(bus.wr_ready), VLEN'(table_v[i].exp_ready));
            check_output($sformatf("row%0d_before", i), bus.rd_data[0], table_v[i].exp_before);
            @(posedge clk);
            model_commit(table_v[i].exp_ready);
            #1;
            check_output($sformatf("row%0d_after", i), bus.rd_data[0], table_v[i].exp_after);
            @(negedge clk);
        end
        clear_writes();
        #1;
        check_output("v0_mask_deadbeef", bus.v0_mask, 128'hDEAD_BEEF);
        @(negedge clk);

        // Randomized traffic over a few registers to force conflicts. Blocked
        // requesters hold their request until accepted.
        held = '0;
        rnd_valid = '0; rnd_idx = '0; rnd_be = '0; rnd_data = '0;
        for (int c = 0; c < 300; c++) begin
            for (int w = 0; w < NWR; w++) begin
                if (!held[w]) begin
                    rnd_valid[w] = 1'($urandom_range(0, 1));
                    rnd_idx[w]   = 5'($urandom_range(0, 7));
                    case ($urandom_range(0, 3))
                        0:       rnd_be[w] = 16'h0000;
                        1:       rnd_be[w] = 16'hFFFF;
                        default: rnd_be[w] = 16'($urandom);
                    endcase
                    rnd_data[w] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            apply_stimulus(rnd_valid, rnd_idx, rnd_be, rnd_data);
            for (int p = 0; p < NRD; p++) bus.rd_index[p] = 5'($urandom_range(0, 9));
            #1;
            exp_r = model_ready();
            check_output($sformatf("rnd%0d_ready", c), VLEN'(bus.wr_ready), VLEN'(exp_r));
            for (int p = 0; p < NRD; p++)
                check_output($sformatf("rnd%0d_rd%0d", c, p), bus.rd_data[p], model_mem[bus.rd_index[p]]);
            check_output($sformatf("rnd%0d_v0", c), bus.v0_mask, model_mem[0]);
            @(posedge clk);
            model_commit(exp_r);
            held = cur_valid & ~exp_r;
            @(negedge clk);
        end

        // Reset in the middle of RUN with writes pending.
        apply_stimulus(4'b0011, {5'd0, 5'd0, 5'd0, 5'd5}, {NWR{16'hFFFF}}, {NWR{{VLEN{1'b1}}}});
        rst = 1'b1;
        #1;
        check_output("midrun_rst_ready", VLEN'(bus.wr_ready), '0);
        check_output("midrun_rst_init_done", VLEN'(bus.init_done), '0);
        @(negedge clk);
        sweep_and_check("sweep2");
        #1;
        check_output("sweep2_v0", bus.v0_mask, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
